// File: rtl/id_ex_if.sv
// id_ex_if: ID-to-EX stage bus; define ID_EX_PERF_CNT_EN to add the stall/flush counters
interface id_ex_if #(
   parameter int DATA_W = 32
`ifdef ID_EX_PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
);
   logic              PCSrc;
   logic [DATA_W-1:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
   logic [2:0]        FUNCT3_ID;
   logic [6:0]        FUNCT7_ID, OPCODE_ID;
   logic [4:0]        RD_ID, RS1_ID, RS2_ID;
   logic              PC_write, IF_ID_write, VALID_EX;
   logic [DATA_W-1:0] PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
   logic [2:0]        FUNCT3_EX;
   logic [6:0]        FUNCT7_EX;
   logic [4:0]        RD_EX, RS1_EX, RS2_EX;
   logic              RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX;
   logic [1:0]        ALUOp_EX;
`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0]  STALL_CNT, FLUSH_CNT;
`endif

   modport slave (
      input  PCSrc, PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID, FUNCT3_ID, FUNCT7_ID, OPCODE_ID,
             RD_ID, RS1_ID, RS2_ID,
      output PC_write, IF_ID_write, VALID_EX, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
             FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
             MemtoReg_EX, ALUSrc_EX, Branch_EX, ALUOp_EX
`ifdef ID_EX_PERF_CNT_EN
      , output STALL_CNT, FLUSH_CNT
`endif
   );

   modport master (
      output PCSrc, PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID, FUNCT3_ID, FUNCT7_ID, OPCODE_ID,
             RD_ID, RS1_ID, RS2_ID,
      input  PC_write, IF_ID_write, VALID_EX, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
             FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
             MemtoReg_EX, ALUSrc_EX, Branch_EX, ALUOp_EX
`ifdef ID_EX_PERF_CNT_EN
      , input STALL_CNT, FLUSH_CNT
`endif
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: RISC-V ID/EX register with decode, load-use stall and flush; ID_EX_PERF_CNT_EN adds counters
module id_ex_stage #(
   parameter int DATA_W = 32
`ifdef ID_EX_PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input logic     clk,
   input logic     reset,
   id_ex_if.slave  bus
);
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc, imm, rd1, rd2;
      logic [2:0]        f3;
      logic [6:0]        f7;
      logic [4:0]        rd, rs1, rs2;
      logic              rw, mr, mw, m2r, alusrc, br;
      logic [1:0]        aluop;
   } ex_t;

   ex_t  ex_d, ex_q;
   logic is_r, is_i, is_ld, is_st, is_br, dv, rs2_used, stall;

   assign is_r     = bus.OPCODE_ID == 7'b0110011;
   assign is_i     = bus.OPCODE_ID == 7'b0010011;
   assign is_ld    = bus.OPCODE_ID == 7'b0000011;
   assign is_st    = bus.OPCODE_ID == 7'b0100011;
   assign is_br    = bus.OPCODE_ID == 7'b1100011;
   assign dv       = is_r | is_i | is_ld | is_st | is_br;
   assign rs2_used = is_r | is_st | is_br;

   // a flush squashes the ID instruction anyway, so it never needs to stall
   assign stall = ex_q.mr & ex_q.valid & (|ex_q.rd) & dv & ~bus.PCSrc &
                  ((ex_q.rd == bus.RS1_ID) | (rs2_used & (ex_q.rd == bus.RS2_ID)));
   assign bus.PC_write    = ~stall;
   assign bus.IF_ID_write = ~stall;

   // next EX contents: ID fields plus control decoded from the opcode
   always_comb begin
      ex_d        = '0;
      ex_d.valid  = dv;
      ex_d.pc     = bus.PC_ID;
      ex_d.imm    = bus.IMM_ID;
      ex_d.rd1    = bus.REG_DATA1_ID;
      ex_d.rd2    = bus.REG_DATA2_ID;
      ex_d.f3     = bus.FUNCT3_ID;
      ex_d.f7     = bus.FUNCT7_ID;
      ex_d.rd     = bus.RD_ID;
      ex_d.rs1    = bus.RS1_ID;
      ex_d.rs2    = bus.RS2_ID;
      ex_d.rw     = is_r | is_i | is_ld;
      ex_d.mr     = is_ld;
      ex_d.mw     = is_st;
      ex_d.m2r    = is_ld;
      ex_d.alusrc = is_i | is_ld | is_st;
      ex_d.br     = is_br;
      ex_d.aluop  = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
   end

   // pipeline register; flush or stall loads an all-zero bubble
   always_ff @(posedge clk or negedge reset)
      if (!reset) ex_q <= '0;
      else        ex_q <= (bus.PCSrc | stall) ? '0 : ex_d;

   assign bus.VALID_EX     = ex_q.valid;
   assign bus.PC_EX        = ex_q.pc;
   assign bus.IMM_EX       = ex_q.imm;
   assign bus.REG_DATA1_EX = ex_q.rd1;
   assign bus.REG_DATA2_EX = ex_q.rd2;
   assign bus.FUNCT3_EX    = ex_q.f3;
   assign bus.FUNCT7_EX    = ex_q.f7;
   assign bus.RD_EX        = ex_q.rd;
   assign bus.RS1_EX       = ex_q.rs1;
   assign bus.RS2_EX       = ex_q.rs2;
   assign bus.RegWrite_EX  = ex_q.rw;
   assign bus.MemRead_EX   = ex_q.mr;
   assign bus.MemWrite_EX  = ex_q.mw;
   assign bus.MemtoReg_EX  = ex_q.m2r;
   assign bus.ALUSrc_EX    = ex_q.alusrc;
   assign bus.Branch_EX    = ex_q.br;
   assign bus.ALUOp_EX     = ex_q.aluop;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // saturating event counters
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         stall_cnt <= (stall && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
         flush_cnt <= (bus.PCSrc && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
      end

   assign bus.STALL_CNT = stall_cnt;
   assign bus.FLUSH_CNT = flush_cnt;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                          OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

`ifdef ID_EX_PERF_CNT_EN
   id_ex_if #(.DATA_W(32), .CNT_W(2)) bus ();
   id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`else
   id_ex_if #(.DATA_W(32)) bus ();
   id_ex_stage #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

   task automatic drive(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [31:0] d1, d2, imm, pc);
      bus.OPCODE_ID    = op;
      bus.RD_ID        = rd;
      bus.RS1_ID       = rs1;
      bus.RS2_ID       = rs2;
      bus.REG_DATA1_ID = d1;
      bus.REG_DATA2_ID = d2;
      bus.IMM_ID       = imm;
      bus.PC_ID        = pc;
      bus.FUNCT3_ID    = 3'b101;
      bus.FUNCT7_ID    = 7'h20;
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      drive(OP_R, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom);
      tick;
      drive(OP_LD, 5'd7, 5'd1, 5'd2, $urandom, $urandom, $urandom, $urandom);
      tick;
      drive(OP_R, 5'd3, 5'd7, 5'd1, $urandom, $urandom, $urandom, $urandom);
      #1;
      total++; if (bus.PC_write !== 1'b0) begin bad++; $display("FAIL rst_prestall got=%0b exp=0", bus.PC_write); end
      reset = 1'b0;
      #1;
      total++; if (bus.VALID_EX !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", bus.VALID_EX); end
      total++; if (bus.PC_EX !== 32'h0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", bus.PC_EX); end
      total++; if (bus.REG_DATA1_EX !== 32'h0) begin bad++; $display("FAIL rst_rd1 got=%0h exp=0", bus.REG_DATA1_EX); end
      total++; if (bus.MemRead_EX !== 1'b0) begin bad++; $display("FAIL rst_memread got=%0b exp=0", bus.MemRead_EX); end
      total++; if (bus.RD_EX !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", bus.RD_EX); end
      total++; if (bus.PC_write !== 1'b1) begin bad++; $display("FAIL rst_pcwrite got=%0b exp=1", bus.PC_write); end
      total++; if (bus.IF_ID_write !== 1'b1) begin bad++; $display("FAIL rst_ifidwrite got=%0b exp=1", bus.IF_ID_write); end
      tick;
      reset = 1'b1;
      #1;
      total++; if (bus.PC_write !== 1'b1) begin bad++; $display("FAIL rst_release_pcwrite got=%0b exp=1", bus.PC_write); end
      tick;
   endtask

   task automatic test_rtype;
      drive(OP_R, 5'd5, 5'd1, 5'd2, 32'h11, 32'h22, 32'h5, 32'h100);
      tick;
      total++; if (bus.VALID_EX !== 1'b1) begin bad++; $display("FAIL r_valid got=%0b exp=1", bus.VALID_EX); end
      total++; if (bus.RegWrite_EX !== 1'b1) begin bad++; $display("FAIL r_regwrite got=%0b exp=1", bus.RegWrite_EX); end
      total++; if (bus.ALUOp_EX !== 2'b10) begin bad++; $display("FAIL r_aluop got=%0b exp=10", bus.ALUOp_EX); end
      total++; if (bus.ALUSrc_EX !== 1'b0) begin bad++; $display("FAIL r_alusrc got=%0b exp=0", bus.ALUSrc_EX); end
      total++; if (bus.REG_DATA1_EX !== 32'h11) begin bad++; $display("FAIL r_rd1 got=%0h exp=11", bus.REG_DATA1_EX); end
      total++; if (bus.REG_DATA2_EX !== 32'h22) begin bad++; $display("FAIL r_rd2 got=%0h exp=22", bus.REG_DATA2_EX); end
      total++; if (bus.RD_EX !== 5'd5) begin bad++; $display("FAIL r_rd got=%0d exp=5", bus.RD_EX); end
      total++; if (bus.PC_EX !== 32'h100) begin bad++; $display("FAIL r_pc got=%0h exp=100", bus.PC_EX); end
      total++; if (bus.FUNCT7_EX !== 7'h20) begin bad++; $display("FAIL r_f7 got=%0h exp=20", bus.FUNCT7_EX); end
      drive(OP_BR, 5'd0, 5'd4, 5'd6, 32'h1, 32'h2, 32'h40, 32'h104);
      tick;
      total++; if (bus.Branch_EX !== 1'b1 || bus.ALUOp_EX !== 2'b01 || bus.RegWrite_EX !== 1'b0)
         begin bad++; $display("FAIL br_ctrl got=%0b/%0b/%0b exp=1/01/0", bus.Branch_EX, bus.ALUOp_EX, bus.RegWrite_EX); end
      drive(OP_ST, 5'd0, 5'd4, 5'd6, 32'h1, 32'h2, 32'h8, 32'h108);
      tick;
      total++; if (bus.MemWrite_EX !== 1'b1 || bus.ALUSrc_EX !== 1'b1 || bus.ALUOp_EX !== 2'b00)
         begin bad++; $display("FAIL st_ctrl got=%0b/%0b/%0b exp=1/1/00", bus.MemWrite_EX, bus.ALUSrc_EX, bus.ALUOp_EX); end
      drive(OP_BAD, 5'd9, 5'd4, 5'd6, 32'h1, 32'h2, 32'h8, 32'h10c);
      tick;
      total++; if (bus.VALID_EX !== 1'b0 || bus.RegWrite_EX !== 1'b0 || bus.RD_EX !== 5'd9)
         begin bad++; $display("FAIL bad_op got=%0b/%0b/%0d exp=0/0/9", bus.VALID_EX, bus.RegWrite_EX, bus.RD_EX); end
   endtask

   task automatic test_load_use;
      drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h4, 32'h200);
      tick;
      total++; if (bus.MemRead_EX !== 1'b1 || bus.MemtoReg_EX !== 1'b1 || bus.ALUSrc_EX !== 1'b1 || bus.ALUOp_EX !== 2'b00)
         begin bad++; $display("FAIL ld_ctrl got=%0b/%0b/%0b/%0b exp=1/1/1/00", bus.MemRead_EX, bus.MemtoReg_EX, bus.ALUSrc_EX, bus.ALUOp_EX); end
      drive(OP_R, 5'd9, 5'd3, 5'd7, 32'h33, 32'h44, 32'h0, 32'h204);
      #1;
      total++; if (bus.PC_write !== 1'b0 || bus.IF_ID_write !== 1'b0)
         begin bad++; $display("FAIL lu_stall got=%0b/%0b exp=0/0", bus.PC_write, bus.IF_ID_write); end
      tick;
      total++; if (bus.VALID_EX !== 1'b0 || bus.RD_EX !== 5'd0 || bus.REG_DATA1_EX !== 32'h0)
         begin bad++; $display("FAIL lu_bubble got=%0b/%0d/%0h exp=0/0/0", bus.VALID_EX, bus.RD_EX, bus.REG_DATA1_EX); end
      total++; if (bus.PC_write !== 1'b1 || bus.IF_ID_write !== 1'b1)
         begin bad++; $display("FAIL lu_one_cycle got=%0b/%0b exp=1/1", bus.PC_write, bus.IF_ID_write); end
      tick;
      total++; if (bus.VALID_EX !== 1'b1 || bus.RD_EX !== 5'd9 || bus.RS2_EX !== 5'd7 || bus.REG_DATA2_EX !== 32'h44)
         begin bad++; $display("FAIL lu_enter got=%0b/%0d/%0d/%0h exp=1/9/7/44", bus.VALID_EX, bus.RD_EX, bus.RS2_EX, bus.REG_DATA2_EX); end
      drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h4, 32'h208);
      tick;
      drive(OP_ST, 5'd0, 5'd1, 5'd7, 32'h0, 32'h0, 32'h4, 32'h20c);
      #1;
      total++; if (bus.PC_write !== 1'b0) begin bad++; $display("FAIL st_rs2_stall got=%0b exp=0", bus.PC_write); end
      tick;
      tick;
   endtask

   task automatic test_no_stall;
      drive(OP_LD, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h300);
      tick;
      drive(OP_R, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h304);
      #1;
      total++; if (bus.PC_write !== 1'b1) begin bad++; $display("FAIL x0_nostall got=%0b exp=1", bus.PC_write); end
      tick;
      total++; if (bus.VALID_EX !== 1'b1 || bus.RD_EX !== 5'd4) begin bad++; $display("FAIL x0_enter got=%0b/%0d exp=1/4", bus.VALID_EX, bus.RD_EX); end
      drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h308);
      tick;
      drive(OP_I, 5'd8, 5'd2, 5'd7, 32'h0, 32'h0, 32'h3, 32'h30c);
      #1;
      total++; if (bus.PC_write !== 1'b1 || bus.IF_ID_write !== 1'b1)
         begin bad++; $display("FAIL i_rs2_nostall got=%0b/%0b exp=1/1", bus.PC_write, bus.IF_ID_write); end
      tick;
      total++; if (bus.VALID_EX !== 1'b1 || bus.ALUSrc_EX !== 1'b1 || bus.ALUOp_EX !== 2'b11 || bus.IMM_EX !== 32'h3)
         begin bad++; $display("FAIL i_ctrl got=%0b/%0b/%0b/%0h exp=1/1/11/3", bus.VALID_EX, bus.ALUSrc_EX, bus.ALUOp_EX, bus.IMM_EX); end
      drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h310);
      tick;
      drive(OP_BAD, 5'd8, 5'd7, 5'd7, 32'h0, 32'h0, 32'h0, 32'h314);
      #1;
      total++; if (bus.PC_write !== 1'b1) begin bad++; $display("FAIL badop_nostall got=%0b exp=1", bus.PC_write); end
      tick;
   endtask

   task automatic test_flush;
      drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h400);
      tick;
      drive(OP_R, 5'd9, 5'd7, 5'd2, 32'h55, 32'h66, 32'h0, 32'h404);
      bus.PCSrc = 1'b1;
      #1;
      total++; if (bus.PC_write !== 1'b1 || bus.IF_ID_write !== 1'b1)
         begin bad++; $display("FAIL flush_pcwrite got=%0b/%0b exp=1/1", bus.PC_write, bus.IF_ID_write); end
      tick;
      bus.PCSrc = 1'b0;
      #1;
      total++; if (bus.VALID_EX !== 1'b0 || bus.MemRead_EX !== 1'b0 || bus.PC_EX !== 32'h0)
         begin bad++; $display("FAIL flush_bubble got=%0b/%0b/%0h exp=0/0/0", bus.VALID_EX, bus.MemRead_EX, bus.PC_EX); end
      total++; if (bus.PC_write !== 1'b1) begin bad++; $display("FAIL flush_nostall_after got=%0b exp=1", bus.PC_write); end
      tick;
      total++; if (bus.VALID_EX !== 1'b1 || bus.PC_EX !== 32'h404) begin bad++; $display("FAIL flush_next got=%0b/%0h exp=1/404", bus.VALID_EX, bus.PC_EX); end
   endtask

   task automatic test_back_to_back;
      drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h500);
      tick;
      drive(OP_LD, 5'd7, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 32'h504);
      #1;
      total++; if (bus.PC_write !== 1'b1) begin bad++; $display("FAIL b2b_nostall got=%0b exp=1", bus.PC_write); end
      tick;
      drive(OP_LD, 5'd8, 5'd7, 5'd1, 32'h0, 32'h0, 32'h0, 32'h508);
      #1;
      total++; if (bus.PC_write !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%0b exp=0", bus.PC_write); end
      tick;
      tick;
   endtask

`ifdef ID_EX_PERF_CNT_EN
   task automatic test_counters;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      total++; if (bus.STALL_CNT !== 2'd0 || bus.FLUSH_CNT !== 2'd0)
         begin bad++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", bus.STALL_CNT, bus.FLUSH_CNT); end
      for (int n = 0; n < 5; n++) begin
         drive(OP_LD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h600);
         tick;
         drive(OP_R, 5'd9, 5'd7, 5'd2, 32'h0, 32'h0, 32'h0, 32'h604);
         tick;
         tick;
         if (n == 1) begin
            total++; if (bus.STALL_CNT !== 2'd2) begin bad++; $display("FAIL cnt_stall2 got=%0d exp=2", bus.STALL_CNT); end
         end
      end
      total++; if (bus.STALL_CNT !== 2'd3) begin bad++; $display("FAIL cnt_stall_sat got=%0d exp=3", bus.STALL_CNT); end
      bus.PCSrc = 1'b1;
      tick;
      tick;
      bus.PCSrc = 1'b0;
      #1;
      total++; if (bus.FLUSH_CNT !== 2'd2) begin bad++; $display("FAIL cnt_flush got=%0d exp=2", bus.FLUSH_CNT); end
   endtask
`endif

   initial begin
      bus.PCSrc = 1'b0;
      drive(7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick;
      tick;
      reset = 1'b1;
      tick;
      test_reset;
      test_rtype;
      test_load_use;
      test_no_stall;
      test_flush;
      test_back_to_back;
`ifdef ID_EX_PERF_CNT_EN
      test_counters;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
